// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, ALU operations, PC sources and the decode rule.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0100
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    CLS_OTHER, CLS_EXEC_R, CLS_EXEC_I, CLS_BRANCH
  } state_class_e;

  typedef struct packed {
    logic    imem_req;
    logic    dmem_req;
    logic    dmem_we;
    logic    ir_write;
    logic    pc_write;
    pc_src_e pc_src;
    logic    reg_dst;
    logic    alu_src;
    logic    rgf_write;
    logic    mem_to_reg;
    logic    illegal_op;
  } ctrl_t;

  // Successor of DECODE; anything unsupported lands in TRAP.
  function automatic state_e decode_next(input logic [5:0] opcode,
                                         input logic [5:0] funct);
    state_e nxt;
    nxt = S_TRAP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_EXEC_R;
          default:                               nxt = S_TRAP;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_EXEC_I;
      OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
      OP_J:                              nxt = S_JUMP;
      default:                           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_dst;
  logic             alu_src;
  logic             rgf_write;
  logic             mem_to_reg;
  logic [3:0]       alu_op;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, alu_zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_dst,
           alu_src, rgf_write, mem_to_reg, alu_op, illegal_op, retired
  );

  modport slave (
    output opcode, funct, alu_zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_dst,
           alu_src, rgf_write, mem_to_reg, alu_op, illegal_op, retired
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU operation select from captured opcode/funct and the current state class.
// Purely combinational so the pipelined controller can reuse it unchanged.
module mips_alu_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  state_class_e state_class,
  output alu_op_e      alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (state_class)
      CLS_EXEC_R: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_EXEC_I: begin
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_BRANCH: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath selects and enables, and counts retired instructions.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                      clk,
  input logic                      reset,
  mips_multicycle_control_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  ctrl_t            ctrl;
  state_class_e     state_class;
  alu_op_e          alu_op_dec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= bus.opcode;
        funct_q  <= bus.funct;
      end
      if (retire) retired_q <= retired_q + CNT_ONE;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: state_d = decode_next(bus.opcode, bus.funct);
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: begin
        ctrl.alu_src = 1'b1;
        state_d      = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl.rgf_write = 1'b1;
        ctrl.reg_dst   = (opcode_q == OP_RTYPE);
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src = 1'b1;
        state_d      = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.dmem_req = 1'b1;
        if (bus.dmem_ack) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_we  = 1'b1;
        if (bus.dmem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        ctrl.rgf_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.pc_src   = PC_BRANCH;
        ctrl.pc_write = (opcode_q == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: ctrl.illegal_op = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Gate on the live reset so no request or enable can pulse while it is low.
    if (!reset) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  always_comb begin
    case (state_q)
      S_EXEC_R: state_class = CLS_EXEC_R;
      S_EXEC_I: state_class = CLS_EXEC_I;
      S_BRANCH: state_class = CLS_BRANCH;
      default:  state_class = CLS_OTHER;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .opcode      (opcode_q),
    .funct       (funct_q),
    .state_class (state_class),
    .alu_op      (alu_op_dec)
  );

  assign bus.imem_req   = ctrl.imem_req;
  assign bus.dmem_req   = ctrl.dmem_req;
  assign bus.dmem_we    = ctrl.dmem_we;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.alu_src    = ctrl.alu_src;
  assign bus.rgf_write  = ctrl.rgf_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.alu_op     = reset ? alu_op_dec : ALU_ADD;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction expected output traces are built from
// the instruction's phases and compared against the controller every cycle.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(32)) bus ();
  mips_multicycle_control_if #(.CNT_W(2))  bus_w ();

  mips_multicycle_control #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  mips_multicycle_control #(.CNT_W(2))  dut_w (.clk(clk), .reset(reset), .bus(bus_w));

  assign bus_w.opcode   = bus.opcode;
  assign bus_w.funct    = bus.funct;
  assign bus_w.alu_zero = bus.alu_zero;
  assign bus_w.imem_ack = bus.imem_ack;
  assign bus_w.dmem_ack = bus.dmem_ack;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       alu_src;
    logic       rgf_write;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    obs_t o;
    logic ia;
    logic da;
    logic live;
  } step_t;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6;

  int          errors = 0;
  int          checks = 0;
  step_t       plan[$];
  obs_t        exp_o;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_retired = 0;
  string       exp_tag = "idle";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.imem_req   = bus.imem_req;
    o.dmem_req   = bus.dmem_req;
    o.dmem_we    = bus.dmem_we;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_src     = bus.pc_src;
    o.reg_dst    = bus.reg_dst;
    o.alu_src    = bus.alu_src;
    o.rgf_write  = bus.rgf_write;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_op     = bus.alu_op;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      check({exp_tag, " outputs"}, 64'(dut_obs()), 64'(exp_o));
      check({exp_tag, " retired"}, 64'(bus.retired), 64'(exp_retired));
      check({exp_tag, " retired_w"}, 64'(bus_w.retired), 64'(exp_retired[1:0]));
    end
  end

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                       fn == 6'h25 || fn == 6'h2A) ? K_R : K_ILL;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return K_I;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input int kind, input logic [5:0] op,
                                        input logic [5:0] fn);
    if (kind == K_R) begin
      case (fn)
        6'h22: return 4'd1;
        6'h24: return 4'd2;
        6'h25: return 4'd3;
        6'h2A: return 4'd4;
        default: return 4'd0;
      endcase
    end
    if (kind == K_I) begin
      case (op)
        6'h0C: return 4'd2;
        6'h0D: return 4'd3;
        6'h0A: return 4'd4;
        default: return 4'd0;
      endcase
    end
    return 4'd0;
  endfunction

  function automatic void push(input obs_t o, input logic ia, input logic da, input logic live);
    step_t s;
    s.o = o; s.ia = ia; s.da = da; s.live = live;
    plan.push_back(s);
  endfunction

  // Expected trace: iw/dw are cycles of low ack before the ack arrives;
  // stray drives acks high wherever they must be ignored.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                                input int iw, input int dw, input int trap_n, input logic stray);
    obs_t o;
    int kind;
    kind = classify(op, fn);
    plan.delete();
    for (int i = 0; i < iw; i++) begin
      o = '0; o.imem_req = 1'b1; push(o, 1'b0, stray, 1'b1);
    end
    o = '0; o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1, stray, 1'b1);
    o = '0; push(o, stray, stray, 1'b1);
    case (kind)
      K_R, K_I: begin
        o = '0; o.alu_src = (kind == K_I); o.alu_op = alu_of(kind, op, fn);
        push(o, stray, stray, 1'b0);
        o = '0; o.rgf_write = 1'b1; o.reg_dst = (kind == K_R);
        push(o, stray, stray, 1'b0);
      end
      K_LW, K_SW: begin
        o = '0; o.alu_src = 1'b1; push(o, stray, stray, 1'b0);
        for (int i = 0; i <= dw; i++) begin
          o = '0; o.dmem_req = 1'b1; o.dmem_we = (kind == K_SW);
          push(o, stray, (i == dw), 1'b0);
        end
        if (kind == K_LW) begin
          o = '0; o.rgf_write = 1'b1; o.mem_to_reg = 1'b1; push(o, stray, stray, 1'b0);
        end
      end
      K_BR: begin
        o = '0; o.alu_op = 4'd1; o.pc_src = 2'b01;
        o.pc_write = (op == 6'h05) ? ~zero : zero;
        push(o, stray, stray, 1'b0);
      end
      K_J: begin
        o = '0; o.pc_write = 1'b1; o.pc_src = 2'b10; push(o, stray, stray, 1'b0);
      end
      default: begin
        for (int i = 0; i < trap_n; i++) begin
          o = '0; o.illegal_op = 1'b1; push(o, 1'b1, 1'b1, 1'b0);
        end
      end
    endcase
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic zero, input int iw, input int dw, input logic stray,
                     input int limit);
    build(op, fn, zero, iw, dw, 4, stray);
    for (int i = 0; i < plan.size() && (limit < 0 || i < limit); i++) begin
      bus.opcode   = plan[i].live ? op : 6'h3F;
      bus.funct    = plan[i].live ? fn : 6'h3F;
      bus.alu_zero = zero;
      bus.imem_ack = plan[i].ia;
      bus.dmem_ack = plan[i].da;
      exp_o        = plan[i].o;
      exp_tag      = $sformatf("%s c%0d", tag, i);
      exp_valid    = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
    if (limit < 0 && classify(op, fn) != K_ILL) exp_retired = exp_retired + 1;
  endtask

  task automatic apply_reset(input string tag);
    exp_retired = 0;
    reset       = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    exp_o       = '0;
    exp_tag     = tag;
    exp_valid   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n_req;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    #1;
    apply_reset("reset");

    // Pin the trace model with hand-counted figures.
    build(6'h23, 6'h00, 1'b0, 0, 3, 4, 1'b0);
    check("lw latency", 64'(plan.size()), 64'd8);
    n_req = 0;
    foreach (plan[i]) if (plan[i].o.dmem_req) n_req++;
    check("lw dmem_req cycles", 64'(n_req), 64'd4);
    build(6'h02, 6'h00, 1'b0, 0, 0, 4, 1'b0);
    check("j latency", 64'(plan.size()), 64'd3);
    build(6'h2B, 6'h00, 1'b0, 0, 0, 4, 1'b0);
    check("sw latency", 64'(plan.size()), 64'd4);

    run("add", 6'h00, 6'h20, 1'b0, 0, 0, 1'b0, -1);
    check("retired after add", 64'(bus.retired), 64'd1);
    run("lw_d3", 6'h23, 6'h00, 1'b0, 0, 3, 1'b0, -1);
    run("sw", 6'h2B, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 1'b0, -1);
    check("retired_w wraps", 64'(bus_w.retired), 64'd0);
    check("retired at 4", 64'(bus.retired), 64'd4);
    run("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, 1'b0, -1);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("j", 6'h02, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("sub", 6'h00, 6'h22, 1'b0, 2, 0, 1'b1, -1);
    run("and", 6'h00, 6'h24, 1'b0, 0, 0, 1'b1, -1);
    run("or", 6'h00, 6'h25, 1'b0, 1, 0, 1'b0, -1);
    run("slt", 6'h00, 6'h2A, 1'b0, 0, 0, 1'b1, -1);
    run("addi", 6'h08, 6'h3F, 1'b0, 0, 0, 1'b1, -1);
    run("andi", 6'h0C, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("ori", 6'h0D, 6'h00, 1'b0, 0, 0, 1'b1, -1);
    run("slti", 6'h0A, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    run("lw_stray", 6'h23, 6'h00, 1'b0, 1, 0, 1'b1, -1);
    run("sw_d2", 6'h2B, 6'h00, 1'b0, 0, 2, 1'b1, -1);
    check("retired at 18", 64'(bus.retired), 64'd18);

    run("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    apply_reset("ill_op reset");
    run("ill_fn", 6'h00, 6'h00, 1'b0, 0, 0, 1'b0, -1);
    apply_reset("ill_fn reset");

    // Abort a store while it waits in the memory-write state.
    run("sw_abort", 6'h2B, 6'h00, 1'b0, 0, 5, 1'b0, 4);
    bus.dmem_ack = 1'b0;
    check("abort dmem_req before", 64'(bus.dmem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort dmem_req after", 64'(bus.dmem_req), 64'd0);
    check("abort dmem_we after", 64'(bus.dmem_we), 64'd0);
    check("abort imem_req after", 64'(bus.imem_req), 64'd0);
    exp_retired = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run("add_after_abort", 6'h00, 6'h20, 1'b0, 0, 0, 1'b0, -1);
    check("retired after abort", 64'(bus.retired), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
